// File: rtl/router_pkg.sv
// Shared constants and types for the router output-channel FIFO.
// Header byte layout: [DATA_W-1:LEN_LSB] payload length, [ADDR_W-1:0] destination.
package router_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int ADDR_W     = 2;
  localparam int LEN_LSB    = ADDR_W;

  typedef struct packed {
    logic                  sop;
    logic [DEF_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/router_pkt_fifo_if.sv
// Write/read/status bundle between the router core, the channel FIFO and the read port.
// master drives write/read requests; slave is the FIFO.
interface router_pkt_fifo_if
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic              write_enb;
  logic              sop_in;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              sop_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AW:0]       count;
  logic [DATA_W-3:0] pkt_remaining;
  logic              overflow;
  logic              underflow;

  modport master (
    output write_enb, sop_in, data_in, read_enb,
    input  data_out, sop_out, data_valid, full, empty, almost_full, almost_empty,
           count, pkt_remaining, overflow, underflow
  );

  modport slave (
    input  write_enb, sop_in, data_in, read_enb,
    output data_out, sop_out, data_valid, full, empty, almost_full, almost_empty,
           count, pkt_remaining, overflow, underflow
  );

endinterface

// File: rtl/router_fifo_ram.sv
// DEPTH x (DATA_W+1) storage of {sop, data}: one write port, one registered read port.
// Read data appears the edge after i_rd_en and holds otherwise; no reset on the array.
module router_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DATA_W:0] i_wr_dat,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DATA_W:0] o_rd_dat
);

  logic [DATA_W:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
    if (i_rd_en) o_rd_dat <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware channel FIFO: pointers, occupancy, packet byte counter and sticky errors.
// Read latency 1 cycle; writes while full and reads while empty are dropped and flagged.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AW        = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic soft_reset,
  router_pkt_fifo_if.slave bus
);

  localparam logic [AW:0] L_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AFULL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] L_AEMPTY = (AW+1)'(AEMPTY_TH);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-3:0] r_pkt_base;
  logic              r_data_valid;
  logic              r_out_clr;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [DATA_W:0]   w_ram_q;
  logic              w_q_sop;
  logic [DATA_W-3:0] w_len;
  logic [DATA_W-3:0] w_pkt_next;

  assign w_full   = (r_count == L_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.write_enb && !w_full;
  assign w_rd_acc = bus.read_enb && !w_empty;

  router_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk     (clock),
    .i_wr_en   (w_wr_acc && !soft_reset),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  ({bus.sop_in, bus.data_in}),
    .i_rd_en   (w_rd_acc && !soft_reset),
    .i_rd_addr (r_rd_ptr),
    .o_rd_dat  (w_ram_q)
  );

  assign w_q_sop = w_ram_q[DATA_W];
  assign w_len   = w_ram_q[DATA_W-1:LEN_LSB];

  // r_pkt_base is the count before the byte now on data_out was popped, so the
  // counter moves on the same edge as data_out even though the RAM read is registered.
  always_comb begin
    w_pkt_next = r_pkt_base;
    if (r_data_valid) begin
      if (w_q_sop) begin
        // an all-ones length has no room for the parity byte; pin at max instead of wrapping
        w_pkt_next = (&w_len) ? w_len : w_len + 1'b1;
      end else if (r_pkt_base != '0) begin
        w_pkt_next = r_pkt_base - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pkt_base   <= '0;
      r_data_valid <= 1'b0;
      r_out_clr    <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pkt_base   <= '0;
      r_data_valid <= 1'b0;
      r_out_clr    <= 1'b1;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_out_clr <= 1'b0;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_pkt_base   <= w_pkt_next;
      r_data_valid <= w_rd_acc;
      if (bus.write_enb && w_full) r_overflow  <= 1'b1;
      if (bus.read_enb && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.data_out      = r_out_clr ? '0 : w_ram_q[DATA_W-1:0];
  assign bus.sop_out       = !r_out_clr && w_q_sop;
  assign bus.data_valid    = r_data_valid;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.almost_full   = (r_count >= L_AFULL);
  assign bus.almost_empty  = (r_count <= L_AEMPTY);
  assign bus.count         = r_count;
  assign bus.pkt_remaining = w_pkt_next;
  assign bus.overflow      = r_overflow;
  assign bus.underflow     = r_underflow;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo at 8x16 (u0) and 4x4 with tight thresholds (u1).
module tb_router_pkt_fifo;
  import router_pkg::*;

  logic clock;
  logic resetn;
  logic soft_reset;
  int   checks;
  int   errors;

  router_pkt_fifo_if #(.DATA_W(8), .DEPTH(16)) bus0 ();
  router_pkt_fifo_if #(.DATA_W(4), .DEPTH(4))  bus1 ();

  router_pkt_fifo #(.DATA_W(8), .DEPTH(16)) u0 (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus0)
  );

  router_pkt_fifo #(.DATA_W(4), .DEPTH(4), .AFULL_TH(3), .AEMPTY_TH(1)) u1 (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  fifo_entry_t pkt1  [5] = '{'{1'b1, 8'h0E}, '{1'b0, 8'hA1}, '{1'b0, 8'hA2}, '{1'b0, 8'hA3}, '{1'b0, 8'h5C}};
  logic [4:0]  rem1  [5] = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
  logic [7:0]  fillv [16] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87,
                              8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};
  fifo_entry_t trunc [6] = '{'{1'b1, 8'h0E}, '{1'b0, 8'hA1}, '{1'b1, 8'h06},
                             '{1'b0, 8'hB1}, '{1'b0, 8'hC7}, '{1'b0, 8'hD8}};
  logic [5:0]  remt  [6] = '{6'd4, 6'd3, 6'd2, 6'd1, 6'd0, 6'd0};
  logic        ae1   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        af1   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    soft_reset = 1'b0;
    bus0.write_enb = 1'b0; bus0.sop_in = 1'b0; bus0.data_in = '0; bus0.read_enb = 1'b0;
    bus1.write_enb = 1'b0; bus1.sop_in = 1'b0; bus1.data_in = '0; bus1.read_enb = 1'b0;
    #12;
    chk("rst_count", bus0.count, 0);
    chk("rst_empty", bus0.empty, 1);
    chk("rst_aempty", bus0.almost_empty, 1);
    chk("rst_full", bus0.full, 0);
    chk("rst_dv", bus0.data_valid, 0);
    chk("rst_dout", bus0.data_out, 0);
    chk("rst_prem", bus0.pkt_remaining, 0);
    step();
    resetn = 1'b1;
    step();

    // single packet: header len 3 -> 4 bytes left after the header
    for (int i = 0; i < 5; i++) begin
      bus0.write_enb = 1'b1; bus0.sop_in = pkt1[i].sop; bus0.data_in = pkt1[i].data;
      step();
    end
    bus0.write_enb = 1'b0; bus0.sop_in = 1'b0;
    chk("p1_count", bus0.count, 5);
    bus0.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p1_dout", bus0.data_out, pkt1[i].data);
      chk("p1_sop", bus0.sop_out, pkt1[i].sop);
      chk("p1_dv", bus0.data_valid, 1);
      chk("p1_prem", bus0.pkt_remaining, rem1[i]);
    end
    bus0.read_enb = 1'b0;
    chk("p1_count0", bus0.count, 0);
    step();
    chk("p1_idle_dv", bus0.data_valid, 0);
    chk("p1_idle_dout", bus0.data_out, 8'h5C);

    // fill to full across pointer wrap, then overflow
    for (int i = 0; i < 16; i++) begin
      bus0.write_enb = 1'b1; bus0.data_in = fillv[i];
      step();
    end
    chk("fill_full", bus0.full, 1);
    chk("fill_count", bus0.count, 16);
    chk("fill_afull", bus0.almost_full, 1);
    bus0.data_in = 8'h77;
    step();
    chk("ovf_count", bus0.count, 16);
    chk("ovf_flag", bus0.overflow, 1);
    bus0.read_enb = 1'b1;
    step();
    chk("rw_full_count", bus0.count, 15);
    chk("rw_full_dout", bus0.data_out, fillv[0]);
    bus0.write_enb = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("drain_dout", bus0.data_out, fillv[i]);
    end
    bus0.read_enb = 1'b0;
    chk("drain_empty", bus0.empty, 1);

    // simultaneous read/write at count 8
    for (int i = 0; i < 8; i++) begin
      bus0.write_enb = 1'b1; bus0.data_in = fillv[i+8];
      step();
    end
    chk("mid_count", bus0.count, 8);
    bus0.data_in = 8'h99; bus0.read_enb = 1'b1;
    step();
    chk("rw_mid_count", bus0.count, 8);
    chk("rw_mid_dout", bus0.data_out, fillv[8]);
    bus0.write_enb = 1'b0;
    chk("udf_pre", bus0.underflow, 0);
    for (int i = 0; i < 8; i++) step();
    chk("mid_drain_count", bus0.count, 0);
    chk("mid_last_dout", bus0.data_out, 8'h99);

    // read while empty, then soft reset
    step();
    chk("udf_dv", bus0.data_valid, 0);
    chk("udf_dout", bus0.data_out, 8'h99);
    chk("udf_flag", bus0.underflow, 1);
    chk("ovf_sticky", bus0.overflow, 1);
    bus0.read_enb = 1'b0; soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk("srst_udf", bus0.underflow, 0);
    chk("srst_ovf", bus0.overflow, 0);
    chk("srst_count", bus0.count, 0);
    chk("srst_dout", bus0.data_out, 0);

    // async reset mid-packet
    for (int i = 0; i < 8; i++) begin
      bus0.write_enb = 1'b1;
      bus0.sop_in = (i == 0);
      bus0.data_in = (i < 5) ? pkt1[i].data : fillv[i];
      step();
    end
    bus0.write_enb = 1'b0; bus0.sop_in = 1'b0; bus0.read_enb = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus0.read_enb = 1'b0;
    chk("mid_pkt_count", bus0.count, 5);
    chk("mid_pkt_prem", bus0.pkt_remaining, 2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_count", bus0.count, 0);
    chk("arst_empty", bus0.empty, 1);
    chk("arst_prem", bus0.pkt_remaining, 0);
    chk("arst_dv", bus0.data_valid, 0);
    chk("arst_dout", bus0.data_out, 0);
    #2 resetn = 1'b1;
    step();

    // header arriving before the previous packet finished reloads the counter
    for (int i = 0; i < 6; i++) begin
      bus0.write_enb = 1'b1; bus0.sop_in = trunc[i].sop; bus0.data_in = trunc[i].data;
      step();
    end
    bus0.write_enb = 1'b0; bus0.sop_in = 1'b0; bus0.read_enb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("trunc_sop", bus0.sop_out, trunc[i].sop);
      chk("trunc_prem", bus0.pkt_remaining, remt[i]);
    end
    bus0.read_enb = 1'b0;
    chk("trunc_count", bus0.count, 0);

    // small instance: thresholds at every occupancy, saturating 2-bit length
    chk("s_ae", bus1.almost_empty, ae1[0]);
    chk("s_af", bus1.almost_full, af1[0]);
    for (int i = 1; i <= 4; i++) begin
      bus1.write_enb = 1'b1;
      bus1.sop_in = (i == 1);
      bus1.data_in = (i == 1) ? 4'hE : 4'(i);
      step();
      chk("s_count", bus1.count, i);
      chk("s_ae", bus1.almost_empty, ae1[i]);
      chk("s_af", bus1.almost_full, af1[i]);
    end
    bus1.write_enb = 1'b0; bus1.sop_in = 1'b0;
    chk("s_full", bus1.full, 1);
    bus1.read_enb = 1'b1;
    step();
    bus1.read_enb = 1'b0;
    chk("s_dout", bus1.data_out, 4'hE);
    chk("s_prem_sat", bus1.pkt_remaining, 3);
    chk("s_count3", bus1.count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
